// File: rtl/prng_ctrl_pkg.sv
// Shared types and constants for the PRNG controller and its round-robin arbiter.
package prng_ctrl_pkg;

  localparam int unsigned PRNG_W = 256;

  typedef enum logic [1:0] {
    StLoad,
    StWarmup,
    StReady
  } prng_ctrl_state_t;

  localparam logic [PRNG_W-1:0] DEFAULT_SEED_C = {32{8'hA5}};

  // Index width for a requester vector; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prng_ctrl_256_if.sv
// Consumer-side bus of the PRNG controller: seeding, requests, grants and delivered words.
interface prng_ctrl_256_if #(
  parameter int unsigned NUM_REQ = 4
) ();

  logic                                           seed_valid;
  logic [prng_ctrl_pkg::PRNG_W-1:0]               seed;
  logic [NUM_REQ-1:0]                             req;
  logic [NUM_REQ-1:0]                             gnt;
  logic                                           rnd_valid;
  logic [prng_ctrl_pkg::idx_w(NUM_REQ)-1:0]       rnd_id;
  logic [prng_ctrl_pkg::PRNG_W-1:0]               rnd_data;

  modport master (
    output seed_valid, seed, req,
    input  gnt, rnd_valid, rnd_id, rnd_data
  );

  modport slave (
    input  seed_valid, seed, req,
    output gnt, rnd_valid, rnd_id, rnd_data
  );

endinterface

// File: rtl/prng_ctrl_256_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 (mod NUM_REQ) for the first request.
module rr_arbiter
  import prng_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [idx_w(NUM_REQ)-1:0] last,
  input  logic                      en,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [idx_w(NUM_REQ)-1:0] gnt_idx,
  output logic                      gnt_any
);

  localparam int unsigned IdW = idx_w(NUM_REQ);

  logic [IdW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    // Offset NUM_REQ wraps back to last itself, so it is the lowest-priority candidate.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdW'((32'(last) + i) % NUM_REQ);
      if (en && !gnt_any && req[cand]) begin
        gnt_any   = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/prng_ctrl_256.sv
// Sequences the PRNG core through seed load and warm-up, then hands each core word to exactly
// one requester via round-robin grants, with user-requested and periodic re-seeding.
module prng_ctrl_256
  import prng_ctrl_pkg::*;
#(
  parameter int unsigned       NUM_REQ         = 4,
  parameter int unsigned       WARMUP_CYCLES   = 16,
  parameter int unsigned       RESEED_INTERVAL = 1024,
  parameter logic [PRNG_W-1:0] DEFAULT_SEED    = DEFAULT_SEED_C
) (
  input  logic              clk,
  input  logic              rst,
  prng_ctrl_256_if.slave    bus,
  output logic              prng_load,
  output logic [PRNG_W-1:0] prng_seed,
  output logic              prng_en,
  input  logic [PRNG_W-1:0] prng_data,
  output logic              busy
);

  localparam int unsigned IdW   = idx_w(NUM_REQ);
  localparam int unsigned WarmW = $clog2(WARMUP_CYCLES + 1);
  localparam int unsigned GcntW = (RESEED_INTERVAL > 0) ? $clog2(RESEED_INTERVAL + 1) : 1;

  localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_CYCLES - 1);
  localparam logic [GcntW-1:0] GcntMax  = GcntW'(RESEED_INTERVAL);
  localparam logic [IdW-1:0]   LastRst  = IdW'(NUM_REQ - 1);

  prng_ctrl_state_t  state_q, state_d;
  logic [WarmW-1:0]  warm_cnt_q, warm_cnt_d;
  logic [GcntW-1:0]  grant_cnt_q, grant_cnt_d;
  logic [PRNG_W-1:0] seed_q, seed_d;
  logic [IdW-1:0]    last_q, last_d;
  logic              rnd_valid_q, rnd_valid_d;
  logic [IdW-1:0]    rnd_id_q, rnd_id_d;
  logic [PRNG_W-1:0] rnd_data_q, rnd_data_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IdW-1:0]     gnt_idx;
  logic               gnt_any;
  logic               arb_en;

  // A pending seed always takes priority over handing out a word.
  assign arb_en = (state_q == StReady) && !bus.seed_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (bus.req),
    .last    (last_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    grant_cnt_d = grant_cnt_q;
    seed_d      = seed_q;
    last_d      = last_q;
    rnd_valid_d = gnt_any;
    rnd_id_d    = rnd_id_q;
    rnd_data_d  = rnd_data_q;
    prng_load   = 1'b0;
    prng_en     = 1'b0;
    busy        = 1'b0;

    if (gnt_any) begin
      last_d     = gnt_idx;
      rnd_id_d   = gnt_idx;
      rnd_data_d = prng_data;
    end

    unique case (state_q)
      StLoad: begin
        prng_load   = 1'b1;
        busy        = 1'b1;
        warm_cnt_d  = '0;
        grant_cnt_d = '0;
        state_d     = StWarmup;
      end
      StWarmup: begin
        prng_en = 1'b1;
        busy    = 1'b1;
        if (warm_cnt_q == WarmLast) begin
          state_d = StReady;
        end else begin
          warm_cnt_d = warm_cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (gnt_any) begin
          // Advance on every grant so no word is ever delivered twice.
          prng_en = 1'b1;
          if (RESEED_INTERVAL != 0) begin
            grant_cnt_d = grant_cnt_q + 1'b1;
            if (grant_cnt_d == GcntMax) begin
              grant_cnt_d = '0;
              seed_d      = seed_q ^ prng_data;
              state_d     = StLoad;
            end
          end
        end
      end
      default: state_d = StLoad;
    endcase

    if (bus.seed_valid) begin
      seed_d  = bus.seed;
      state_d = StLoad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      warm_cnt_q  <= '0;
      grant_cnt_q <= '0;
      seed_q      <= DEFAULT_SEED;
      last_q      <= LastRst;
      rnd_valid_q <= 1'b0;
      rnd_id_q    <= '0;
      rnd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      grant_cnt_q <= grant_cnt_d;
      seed_q      <= seed_d;
      last_q      <= last_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_id_q    <= rnd_id_d;
      rnd_data_q  <= rnd_data_d;
    end
  end

  assign prng_seed     = seed_q;
  assign bus.gnt       = gnt;
  assign bus.rnd_valid = rnd_valid_q;
  assign bus.rnd_id    = rnd_id_q;
  assign bus.rnd_data  = rnd_data_q;

endmodule

// File: tb/tb_prng_ctrl_256.sv
// Directed bench for prng_ctrl_256 with behavioural 1-cycle PRNG core models.
module tb_prng_ctrl_256;
  import prng_ctrl_pkg::*;

  localparam int unsigned N = 4;
  localparam logic [PRNG_W-1:0] Mix = 256'h9E3779B97F4A7C15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  prng_ctrl_256_if #(.NUM_REQ(N)) bus ();
  prng_ctrl_256_if #(.NUM_REQ(N)) bus_rs ();

  logic              prng_load, prng_en, busy;
  logic [PRNG_W-1:0] prng_seed;
  logic [PRNG_W-1:0] prng_data = '0;
  logic              rs_load, rs_en, rs_busy;
  logic [PRNG_W-1:0] rs_seed;
  logic [PRNG_W-1:0] rs_data = '0;

  prng_ctrl_256 #(
    .NUM_REQ(N), .WARMUP_CYCLES(4), .RESEED_INTERVAL(1024), .DEFAULT_SEED(DEFAULT_SEED_C)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .prng_load(prng_load), .prng_seed(prng_seed),
    .prng_en(prng_en), .prng_data(prng_data), .busy(busy)
  );

  prng_ctrl_256 #(
    .NUM_REQ(N), .WARMUP_CYCLES(4), .RESEED_INTERVAL(3), .DEFAULT_SEED(DEFAULT_SEED_C)
  ) dut_rs (
    .clk(clk), .rst(rst), .bus(bus_rs), .prng_load(rs_load), .prng_seed(rs_seed),
    .prng_en(rs_en), .prng_data(rs_data), .busy(rs_busy)
  );

  function automatic logic [PRNG_W-1:0] core_step(input logic [PRNG_W-1:0] c);
    return (c ^ (c << 13) ^ (c >> 7)) + Mix;
  endfunction

  always @(posedge clk) begin
    if (prng_load) prng_data <= prng_seed;
    else if (prng_en) prng_data <= core_step(prng_data);
    if (rs_load) rs_data <= rs_seed;
    else if (rs_en) rs_data <= core_step(rs_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.seed_valid = 1'b0; bus.seed = '0; bus.req = 4'b1111;
    bus_rs.seed_valid = 1'b0; bus_rs.seed = '0; bus_rs.req = 4'b0000;
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({bus.gnt, bus.rnd_valid, bus.rnd_id, prng_en, prng_load, busy} !== 10'b0000_0_00_0_1_1) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000011",
               {bus.gnt, bus.rnd_valid, bus.rnd_id, prng_en, prng_load, busy});
    end
    n_checks++;
    if (bus.rnd_data !== '0 || prng_seed !== DEFAULT_SEED_C) begin
      n_fail++;
      $display("FAIL reset_data: got data %h seed %h", bus.rnd_data, prng_seed);
    end
  endtask

  task automatic test_bringup();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({prng_load, busy, prng_en, bus.gnt} !== 7'b1_1_0_0000 || prng_seed !== DEFAULT_SEED_C) begin
      n_fail++;
      $display("FAIL bringup_load: got %b seed %h", {prng_load, busy, prng_en, bus.gnt}, prng_seed);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if ({prng_load, busy, prng_en, bus.gnt} !== 7'b0_1_1_0000) begin
        n_fail++;
        $display("FAIL bringup_warm%0d: got %b expected 0110000", c,
                 {prng_load, busy, prng_en, bus.gnt});
      end
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({prng_load, busy, prng_en, bus.gnt} !== 7'b0_0_1_0001) begin
      n_fail++;
      $display("FAIL bringup_first_gnt: got %b expected 0010001", {prng_load, busy, prng_en, bus.gnt});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]        exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]        exp_i [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [PRNG_W-1:0] words [5];
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        tick();
        @(negedge clk);
      end
      n_checks++;
      if ({prng_en, bus.gnt} !== {1'b1, exp_g[k]}) begin
        n_fail++;
        $display("FAIL rr_gnt%0d: got %b expected 1%b", k, {prng_en, bus.gnt}, exp_g[k]);
      end
      if (k > 0) begin
        n_checks++;
        if (!bus.rnd_valid || bus.rnd_id !== exp_i[k-1] || bus.rnd_data !== words[k-1]) begin
          n_fail++;
          $display("FAIL rr_rnd%0d: got v=%b id=%0d data=%h expected id=%0d data=%h", k-1,
                   bus.rnd_valid, bus.rnd_id, bus.rnd_data, exp_i[k-1], words[k-1]);
        end
      end
      words[k] = prng_data;
    end
    tick();
    bus.req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (!bus.rnd_valid || bus.rnd_id !== 2'd0 || bus.rnd_data !== words[4] || bus.gnt !== 4'b0) begin
      n_fail++;
      $display("FAIL rr_rnd4: got v=%b id=%0d gnt=%b data=%h expected id=0 data=%h",
               bus.rnd_valid, bus.rnd_id, bus.gnt, bus.rnd_data, words[4]);
    end
  endtask

  task automatic test_sparse();
    logic [3:0]        exp_g [3] = '{4'b0100, 4'b0001, 4'b0100};
    logic [1:0]        exp_i [3] = '{2'd2, 2'd0, 2'd2};
    logic [PRNG_W-1:0] words [3];
    tick();
    bus.req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== exp_g[k]) begin
        n_fail++;
        $display("FAIL sparse_gnt%0d: got %b expected %b", k, bus.gnt, exp_g[k]);
      end
      n_checks++;
      if (k == 0 ? (bus.rnd_valid !== 1'b0)
                 : (!bus.rnd_valid || bus.rnd_id !== exp_i[k-1] || bus.rnd_data !== words[k-1])) begin
        n_fail++;
        $display("FAIL sparse_rnd%0d: got v=%b id=%0d data=%h", k, bus.rnd_valid, bus.rnd_id,
                 bus.rnd_data);
      end
      words[k] = prng_data;
    end
    tick();
    bus.req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (!bus.rnd_valid || bus.rnd_id !== 2'd2 || bus.rnd_data !== words[2]) begin
      n_fail++;
      $display("FAIL sparse_rnd_last: got v=%b id=%0d data=%h expected id=2 data=%h",
               bus.rnd_valid, bus.rnd_id, bus.rnd_data, words[2]);
    end
  endtask

  task automatic test_seed_collision();
    logic [PRNG_W-1:0] w;
    tick();
    bus.seed_valid = 1'b1; bus.seed = 256'h1; bus.req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if ({prng_en, bus.gnt, busy} !== 6'b0_0000_0) begin
      n_fail++;
      $display("FAIL collide_gnt: got %b expected 000000", {prng_en, bus.gnt, busy});
    end
    tick();
    bus.seed_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({prng_load, busy, prng_en, bus.gnt} !== 7'b1_1_0_0000 || prng_seed !== 256'h1) begin
      n_fail++;
      $display("FAIL collide_load: got %b seed %h expected seed 1",
               {prng_load, busy, prng_en, bus.gnt}, prng_seed);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if ({prng_load, busy, prng_en, bus.gnt} !== 7'b0_1_1_0000) begin
        n_fail++;
        $display("FAIL collide_warm%0d: got %b expected 0110000", c,
                 {prng_load, busy, prng_en, bus.gnt});
      end
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({busy, bus.gnt} !== 5'b0_0100) begin
      n_fail++;
      $display("FAIL collide_gnt_after: got %b expected 00100", {busy, bus.gnt});
    end
    w = prng_data;
    tick();
    bus.req = 4'b0000;
    @(negedge clk);
    n_checks++;
    if (!bus.rnd_valid || bus.rnd_id !== 2'd2 || bus.rnd_data !== w) begin
      n_fail++;
      $display("FAIL collide_rnd: got v=%b id=%0d data=%h expected id=2 data=%h",
               bus.rnd_valid, bus.rnd_id, bus.rnd_data, w);
    end
  endtask

  task automatic test_reset_midop();
    tick();
    bus.seed_valid = 1'b1; bus.seed = 256'hDEAD;
    tick();
    bus.seed_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.gnt, bus.rnd_valid, bus.rnd_id, prng_en, prng_load, busy} !== 10'b0000_0_00_0_1_1 ||
        prng_seed !== DEFAULT_SEED_C) begin
      n_fail++;
      $display("FAIL midwarm_reset: got %b seed %h",
               {bus.gnt, bus.rnd_valid, bus.rnd_id, prng_en, prng_load, busy}, prng_seed);
    end
    rst = 1'b0;
    bus.req = 4'b0010;
    for (int c = 1; c <= 4; c++) tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({prng_en, busy, bus.gnt} !== 6'b1_0_0010) begin
      n_fail++;
      $display("FAIL restart_gnt: got %b expected 100010", {prng_en, busy, bus.gnt});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (!bus.rnd_valid || bus.rnd_id !== 2'd1 || bus.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL restart_rnd: got v=%b id=%0d gnt=%b expected v=1 id=1 gnt=0010",
               bus.rnd_valid, bus.rnd_id, bus.gnt);
    end
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if ({bus.gnt, bus.rnd_valid, bus.rnd_id, prng_en, prng_load, busy} !== 10'b0000_0_00_0_1_1 ||
        bus.rnd_data !== '0 || prng_seed !== DEFAULT_SEED_C) begin
      n_fail++;
      $display("FAIL midgrant_reset: got %b data %h seed %h",
               {bus.gnt, bus.rnd_valid, bus.rnd_id, prng_en, prng_load, busy}, bus.rnd_data, prng_seed);
    end
    rst = 1'b0;
    bus.req = 4'b0000;
  endtask

  task automatic test_auto_reseed();
    logic [3:0]        exp_g [3] = '{4'b0001, 4'b0010, 4'b0100};
    logic [PRNG_W-1:0] w;
    tick();
    rst = 1'b1;
    bus_rs.req = 4'b1111;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      n_checks++;
      if (bus_rs.gnt !== exp_g[k]) begin
        n_fail++;
        $display("FAIL reseed_gnt%0d: got %b expected %b", k, bus_rs.gnt, exp_g[k]);
      end
    end
    n_checks++;
    if (dut_rs.grant_cnt_q !== 2'd2) begin
      n_fail++;
      $display("FAIL reseed_cnt_before: got %0d expected 2", dut_rs.grant_cnt_q);
    end
    w = rs_data;
    tick();
    @(negedge clk);
    n_checks++;
    if (!bus_rs.rnd_valid || bus_rs.rnd_id !== 2'd2 || bus_rs.rnd_data !== w) begin
      n_fail++;
      $display("FAIL reseed_rnd: got v=%b id=%0d data=%h expected id=2 data=%h",
               bus_rs.rnd_valid, bus_rs.rnd_id, bus_rs.rnd_data, w);
    end
    n_checks++;
    if ({rs_load, rs_busy, bus_rs.gnt} !== 6'b1_1_0000 || rs_seed !== (DEFAULT_SEED_C ^ w) ||
        dut_rs.grant_cnt_q !== 2'd0) begin
      n_fail++;
      $display("FAIL reseed_load: got %b cnt %0d seed %h expected seed %h",
               {rs_load, rs_busy, bus_rs.gnt}, dut_rs.grant_cnt_q, rs_seed, DEFAULT_SEED_C ^ w);
    end
    for (int c = 1; c <= 4; c++) tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (bus_rs.gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL reseed_resume: got %b expected 1000", bus_rs.gnt);
    end
    bus_rs.req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_round_robin();
    test_sparse();
    test_seed_collision();
    test_reset_midop();
    test_auto_reseed();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
